// File: rtl/basic_circuits_pkg.sv
// Shared types and constants for the basic_circuits set.
// Holds the serial adder controller state encoding.
package basic_circuits_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder built from two half adders and an OR.
// half_adder is the primitive cell of the basic_circuits set.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .a     (a),
        .b     (b),
        .sum   (s0),
        .carry (c0)
    );

    half_adder u_ha1 (
        .a     (s0),
        .b     (cin),
        .sum   (sum),
        .carry (c1)
    );

    // Both half-adder carries can never be high together.
    assign cout = c0 | c1;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder, LSB first, one bit per clock.
// Controller and datapath share this file; the cell is full_adder.
module serial_adder
    import basic_circuits_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             co_q, co_d;

    logic fa_s;
    logic fa_co;

    full_adder u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (c_q),
        .sum  (fa_s),
        .cout (fa_co)
    );

    // Next-state and datapath update; everything holds by default.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        c_d     = c_q;
        sum_d   = sum_q;
        co_d    = co_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    r_d     = '0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                r_d   = {fa_s, r_q[WIDTH-1:1]};
                c_d   = fa_co;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = {fa_s, r_q[WIDTH-1:1]};
                    co_d    = fa_co;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
        end
    end

    assign busy      = (state_q == SHIFT);
    assign done      = (state_q == DONE);
    assign sum       = sum_q;
    assign carry_out = co_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=2.
// Expected sums are queued at launch and popped on done.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst8, start8, busy8, done8, co8;
    logic [7:0] a8, b8, sum8;
    logic       rst2, start2, busy2, done2, co2;
    logic [1:0] a2, b2, sum2;

    int vectors = 0;
    int miscompares = 0;
    logic [8:0] q8[$];
    logic [2:0] q2[$];
    logic [8:0] last8;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst8),
        .start     (start8),
        .a         (a8),
        .b         (b8),
        .busy      (busy8),
        .done      (done8),
        .sum       (sum8),
        .carry_out (co8)
    );

    serial_adder #(.WIDTH(2)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst2),
        .start     (start2),
        .a         (a2),
        .b         (b2),
        .busy      (busy2),
        .done      (done2),
        .sum       (sum2),
        .carry_out (co2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst8 = 1'b0; rst2 = 1'b0;
        start8 = 1'b0; start2 = 1'b0;
        a8 = '0; b8 = '0; a2 = '0; b2 = '0;
        step(); step();
        rst8 = 1'b1; rst2 = 1'b1;
        vectors++;
        if ({busy8, done8} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset8_flags: got %b want 00", {busy8, done8});
        end
        vectors++;
        if ({co8, sum8} !== 9'h000) begin
            miscompares++;
            $display("FAIL reset8_result: got %h want 000", {co8, sum8});
        end
        vectors++;
        if ({busy2, done2, co2, sum2} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset2_all: got %b want 00000",
                     {busy2, done2, co2, sum2});
        end
        last8 = 9'h000;
        step();
    endtask

    task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                          input logic [31:0] ign, input logic ign_done,
                          input string nm);
        logic [8:0] exp;
        int done_edge;
        int busy_cnt;
        logic held_ok;
        logic both;
        a8 = av; b8 = bv; start8 = 1'b1;
        step();
        start8 = 1'b0;
        q8.push_back({1'b0, av} + {1'b0, bv});
        a8 = ~av; b8 = 8'($urandom);
        busy_cnt = int'(busy8);
        done_edge = -1;
        held_ok = 1'b1;
        both = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            start8 = (k < 32) ? ign[k] : 1'b0;
            step();
            start8 = 1'b0;
            if (busy8 && done8) both = 1'b1;
            if (done8) begin
                done_edge = k;
                break;
            end
            busy_cnt += int'(busy8);
            if ({co8, sum8} !== last8) held_ok = 1'b0;
        end
        vectors++;
        if (done_edge != 8) begin
            miscompares++;
            $display("FAIL %s_done_edge: got %0d want 8", nm, done_edge);
        end
        vectors++;
        if (busy_cnt != 8 || both) begin
            miscompares++;
            $display("FAIL %s_busy: got %0d cycles (overlap %b) want 8",
                     nm, busy_cnt, both);
        end
        vectors++;
        if (!held_ok) begin
            miscompares++;
            $display("FAIL %s_held: prior result %h not held", nm, last8);
        end
        vectors++;
        if (q8.size() == 0) begin
            miscompares++;
            $display("FAIL %s_result: got %h want nothing queued",
                     nm, {co8, sum8});
        end else begin
            exp = q8.pop_front();
            if ({co8, sum8} !== exp) begin
                miscompares++;
                $display("FAIL %s_result: got %h want %h",
                         nm, {co8, sum8}, exp);
            end
            last8 = exp;
        end
        start8 = ign_done;
        step();
        start8 = 1'b0;
        vectors++;
        if ({busy8, done8} !== 2'b00) begin
            miscompares++;
            $display("FAIL %s_after_done: got %b want 00",
                     nm, {busy8, done8});
        end
        if (ign_done || ign != 0) begin
            step();
            vectors++;
            if ({busy8, done8, co8, sum8} !== {2'b00, last8}) begin
                miscompares++;
                $display("FAIL %s_ignored: got %b/%h want 00/%h",
                         nm, {busy8, done8}, {co8, sum8}, last8);
            end
        end
    endtask

    task automatic test_basic();
        run_op(8'h00, 8'h00, 32'h0, 1'b0, "zero");
        run_op(8'hFF, 8'h01, 32'h0, 1'b0, "ff_01");
        run_op(8'hA5, 8'h5A, 32'h0, 1'b0, "a5_5a");
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp;
        int edges[$];
        a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
        q8.push_back(9'h100);
        for (int k = 0; k <= 30; k++) begin
            step();
            if (k == 0) begin
                a8 = 8'h7F; b8 = 8'h01;
                q8.push_back(9'h080);
            end
            if (k == 10) begin
                a8 = 8'h33; b8 = 8'h44; start8 = 1'b0;
                vectors++;
                if (busy8 !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_reaccept: busy got %b want 1", busy8);
                end
            end
            if (done8) begin
                edges.push_back(k);
                vectors++;
                if (q8.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_result: got %h want nothing",
                             {co8, sum8});
                end else begin
                    exp = q8.pop_front();
                    if ({co8, sum8} !== exp) begin
                        miscompares++;
                        $display("FAIL b2b_result: got %h want %h",
                                 {co8, sum8}, exp);
                    end
                    last8 = exp;
                end
            end
        end
        vectors++;
        if (edges.size() != 2 || edges[0] != 8 || edges[1] != 18) begin
            miscompares++;
            $display("FAIL b2b_spacing: got %0d pulses want 2 at 8,18",
                     edges.size());
        end
        q8.delete();
    endtask

    task automatic test_ignored();
        run_op(8'h12, 8'h34, 32'h0000_0108, 1'b1, "ignored");
    endtask

    task automatic test_reset_mid();
        logic seen;
        a8 = 8'hC3; b8 = 8'h3C; start8 = 1'b1;
        step();
        start8 = 1'b0;
        q8.push_back(9'h0FF);
        step(); step(); step();
        rst8 = 1'b0;
        step();
        rst8 = 1'b1;
        q8.delete();
        last8 = 9'h000;
        vectors++;
        if ({busy8, done8, co8, sum8} !== 11'h000) begin
            miscompares++;
            $display("FAIL midreset_state: got %b/%h want 00/000",
                     {busy8, done8}, {co8, sum8});
        end
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (done8 || busy8) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL midreset_quiet: got activity want none");
        end
        run_op(8'hFF, 8'hFF, 32'h0, 1'b0, "post_reset");
    endtask

    task automatic test_w2();
        logic [2:0] exp;
        logic [3:0] v;
        int done_edge;
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            a2 = v[3:2]; b2 = v[1:0]; start2 = 1'b1;
            step();
            start2 = 1'b0;
            q2.push_back({1'b0, v[3:2]} + {1'b0, v[1:0]});
            a2 = ~v[3:2]; b2 = ~v[1:0];
            done_edge = -1;
            for (int k = 1; k <= 10; k++) begin
                step();
                if (done2) begin
                    done_edge = k;
                    break;
                end
            end
            vectors++;
            if (done_edge != 2) begin
                miscompares++;
                $display("FAIL w2_latency_%0d: got %0d want 2", i, done_edge);
            end
            vectors++;
            exp = q2.pop_front();
            if ({co2, sum2} !== exp) begin
                miscompares++;
                $display("FAIL w2_sum_%0d: got %h want %h",
                         i, {co2, sum2}, exp);
            end
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignored();
        test_reset_mid();
        test_w2();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
